// File: rtl/divider32.sv
// Radix-2 restoring signed divider: 32 trial subtractions on magnitudes, then sign fixup.
// Produces quotient, remainder, divide-by-zero flag and a one-cycle ready pulse.
module divider32 (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_div,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic [31:0] data_remainder,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state,  w_state_nxt;
  logic [W-1:0]    r_rem,    w_rem_nxt;
  logic [W-1:0]    r_quo,    w_quo_nxt;
  logic [W-1:0]    r_abs_b,  w_abs_b_nxt;
  logic            r_qsign,  w_qsign_nxt;
  logic            r_rsign,  w_rsign_nxt;
  logic [CW-1:0]   r_count,  w_count_nxt;
  logic [W-1:0]    r_result, w_result_nxt;
  logic [W-1:0]    r_remout, w_remout_nxt;
  logic            r_exc,    w_exc_nxt;
  logic            r_rdy,    w_rdy_nxt;
  logic            r_busy,   w_busy_nxt;

  logic [W-1:0]    w_abs_a;
  logic [W-1:0]    w_abs_b;
  logic [W:0]      w_rem_sh;
  logic [W:0]      w_trial;

  assign w_abs_a  = data_operandA[W-1] ? W'(-data_operandA) : data_operandA;
  assign w_abs_b  = data_operandB[W-1] ? W'(-data_operandB) : data_operandB;
  // The partial remainder stays below |B| <= 2^31, so 32 stored bits suffice.
  assign w_rem_sh = {r_rem, r_quo[W-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_abs_b};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_rem    <= '0;
      r_quo    <= '0;
      r_abs_b  <= '0;
      r_qsign  <= 1'b0;
      r_rsign  <= 1'b0;
      r_count  <= '0;
      r_result <= '0;
      r_remout <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rem    <= w_rem_nxt;
      r_quo    <= w_quo_nxt;
      r_abs_b  <= w_abs_b_nxt;
      r_qsign  <= w_qsign_nxt;
      r_rsign  <= w_rsign_nxt;
      r_count  <= w_count_nxt;
      r_result <= w_result_nxt;
      r_remout <= w_remout_nxt;
      r_exc    <= w_exc_nxt;
      r_rdy    <= w_rdy_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rem_nxt    = r_rem;
    w_quo_nxt    = r_quo;
    w_abs_b_nxt  = r_abs_b;
    w_qsign_nxt  = r_qsign;
    w_rsign_nxt  = r_rsign;
    w_count_nxt  = r_count;
    w_result_nxt = r_result;
    w_remout_nxt = r_remout;
    w_exc_nxt    = r_exc;
    w_rdy_nxt    = 1'b0;
    w_busy_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (ctrl_div) begin
          w_abs_b_nxt = w_abs_b;
          w_qsign_nxt = data_operandA[W-1] ^ data_operandB[W-1];
          w_rsign_nxt = data_operandA[W-1];
          w_rem_nxt   = '0;
          w_quo_nxt   = w_abs_a;
          w_count_nxt = '0;
          if (data_operandB == '0) begin
            w_result_nxt = '0;
            w_remout_nxt = '0;
            w_exc_nxt    = 1'b1;
            w_rdy_nxt    = 1'b1;
            w_state_nxt  = S_DONE;
          end else begin
            w_state_nxt  = S_ITER;
          end
        end
      end
      S_ITER: begin
        if (!w_trial[W]) begin
          w_rem_nxt = w_trial[W-1:0];
          w_quo_nxt = {r_quo[W-2:0], 1'b1};
        end else begin
          w_rem_nxt = w_rem_sh[W-1:0];
          w_quo_nxt = {r_quo[W-2:0], 1'b0};
        end
        w_count_nxt = CW'(r_count + CW'(1));
        if (r_count == CW'(W - 1)) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_result_nxt = r_qsign ? W'(-r_quo) : r_quo;
        w_remout_nxt = r_rsign ? W'(-r_rem) : r_rem;
        w_exc_nxt    = 1'b0;
        w_rdy_nxt    = 1'b1;
        w_state_nxt  = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign data_result    = r_result;
  assign data_remainder = r_remout;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;

endmodule

// File: tb/tb_divider32.sv
// Scoreboard bench for divider32: directed vectors queued at issue, checked by a monitor on RDY.
module tb_divider32;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        exc;
  } exp_t;

  logic        clock;
  logic        reset_n;
  logic        ctrl_div;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  exp_t sb [$];
  exp_t vecs [16];
  int   passed;
  int   total;
  int   rdy_pulses;
  int   exp_pulses;
  logic prev_rdy;

  divider32 dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_div       (ctrl_div),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] q, input logic [31:0] r, input logic e);
    exp_t t;
    t.a = a; t.b = b; t.q = q; t.r = r; t.exc = e;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) $display("FAIL %s: got %h expected %h", name, act, expv);
    else passed++;
  endtask

  // Monitor: every RDY pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (data_resultRDY) begin
      rdy_pulses++;
      chk("rdy_width", 32'(prev_rdy), 32'd0);
      if (sb.size() == 0) begin
        total++;
        $display("FAIL rdy_unexpected: got result %h rem %h with no pending op",
                 data_result, data_remainder);
      end else begin
        e = sb.pop_front();
        chk("quotient", data_result, e.q);
        chk("remainder", data_remainder, e.r);
        chk("exception", 32'(data_exception), 32'(e.exc));
        if (!e.exc) chk("identity", data_result * e.b + data_remainder, e.a);
      end
    end
    prev_rdy = data_resultRDY;
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_div      = 1'b1;
    @(posedge clock);
    #1;
    ctrl_div      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Returns posedges elapsed after the accept edge when RDY is first seen.
  task automatic wait_rdy(input int base, output int lat);
    lat = base;
    for (int i = 0; i < 45; i++) begin
      @(negedge clock);
      if (data_resultRDY) return;
      @(posedge clock);
      lat++;
    end
  endtask

  task automatic run_op(input exp_t v);
    int lat;
    sb.push_back(v);
    exp_pulses++;
    issue(v.a, v.b);
    wait_rdy(0, lat);
    chk("latency", 32'(lat), v.exc ? 32'd0 : 32'd33);
    chk("busy_in_rdy", 32'(busy), 32'd1);
    @(posedge clock);
    @(negedge clock);
    chk("rdy_dropped", 32'(data_resultRDY), 32'd0);
    if (!v.exc) chk("busy_fall", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int lat;
    passed = 0; total = 0; rdy_pulses = 0; exp_pulses = 0; prev_rdy = 1'b0;
    reset_n = 1'b0; ctrl_div = 1'b0; data_operandA = '0; data_operandB = '0;

    vecs[0]  = mk(32'd7,        32'd2,        32'd3,        32'd1,        1'b0);
    vecs[1]  = mk(32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    vecs[2]  = mk(32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0);
    vecs[3]  = mk(32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0);
    vecs[4]  = mk(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0);
    vecs[5]  = mk(32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0);
    vecs[6]  = mk(32'd5,        32'd0,        32'd0,        32'd0,        1'b1);
    vecs[7]  = mk(32'd100,      32'd7,        32'd14,       32'd2,        1'b0);
    vecs[8]  = mk(32'd0,        32'd5,        32'd0,        32'd0,        1'b0);
    vecs[9]  = mk(32'h7FFFFFFF, 32'd2,        32'h3FFFFFFF, 32'd1,        1'b0);
    vecs[10] = mk(32'h80000000, 32'd2,        32'hC0000000, 32'd0,        1'b0);
    vecs[11] = mk(32'hFFFFFFFF, 32'h80000000, 32'd0,        32'hFFFFFFFF, 1'b0);
    vecs[12] = mk(32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF, 1'b0);
    vecs[13] = mk(32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0);
    vecs[14] = mk(32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, 32'd0,        1'b0);
    vecs[15] = mk(32'h80000000, 32'd0,        32'd0,        32'd0,        1'b1);

    repeat (2) @(posedge clock);
    #1;
    chk("reset_result", data_result, 32'd0);
    chk("reset_rem", data_remainder, 32'd0);
    chk("reset_exc", 32'(data_exception), 32'd0);
    chk("reset_rdy", 32'(data_resultRDY), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) run_op(vecs[i]);
    run_op(vecs[0]);

    // Second start at E10 must be ignored.
    sb.push_back(mk(32'd100, 32'd7, 32'd14, 32'd2, 1'b0));
    exp_pulses++;
    issue(32'd100, 32'd7);
    repeat (9) @(posedge clock);
    @(negedge clock);
    data_operandA = 32'd1;
    data_operandB = 32'd1;
    ctrl_div      = 1'b1;
    @(posedge clock);
    #1;
    ctrl_div = 1'b0;
    wait_rdy(10, lat);
    chk("ignored_start_latency", 32'(lat), 32'd33);
    repeat (4) @(posedge clock);

    // Reset at E15 abandons the operation.
    issue(32'd100, 32'd7);
    repeat (15) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midreset_result", data_result, 32'd0);
    chk("midreset_rem", data_remainder, 32'd0);
    chk("midreset_exc", 32'(data_exception), 32'd0);
    chk("midreset_rdy", 32'(data_resultRDY), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    chk("no_rdy_after_abort", 32'(rdy_pulses), 32'(exp_pulses));
    run_op(vecs[7]);
    run_op(vecs[3]);

    repeat (3) @(negedge clock);
    chk("rdy_pulse_count", 32'(rdy_pulses), 32'(exp_pulses));
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
